// File: rtl/pio_in_edge_irq.sv
// pio_in_edge_irq: Avalon-MM input PIO with per-bit synchronisation,
// programmable rising/falling edge capture, level- or edge-sensitive
// interrupt and a saturating event counter.
// Optional feature: define PIO_IN_DEBOUNCE_EN to insert a per-bit
// debounce filter between the synchroniser and the edge detector.
module pio_in_edge_irq #(
  parameter int WIDTH           = 32,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_WIDTH       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [2:0] ADDR_DATA  = 3'd0;
  localparam logic [2:0] ADDR_RISE  = 3'd1;
  localparam logic [2:0] ADDR_MASK  = 3'd2;
  localparam logic [2:0] ADDR_CAP   = 3'd3;
  localparam logic [2:0] ADDR_FALL  = 3'd4;
  localparam logic [2:0] ADDR_MODE  = 3'd5;
  localparam logic [2:0] ADDR_CNT   = 3'd7;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  // Bus decode
  logic             w_wr;
  logic [WIDTH-1:0] w_wdata;
  logic             w_unused;

  assign w_wr     = chipselect & ~write_n;
  assign w_wdata  = writedata[WIDTH-1:0];
  // Upper write-data bits beyond WIDTH carry no meaning.
  assign w_unused = ^writedata;

  // Input path
  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0]                  w_sync;
  logic [WIDTH-1:0]                  w_filt;
  logic [WIDTH-1:0]                  r_prev;

  // Shift the asynchronous inputs through the synchroniser chain
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], in_port};
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef PIO_IN_DEBOUNCE_EN
  localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

  genvar gi;
  for (gi = 0; gi < WIDTH; gi++) begin : g_db
    logic [DB_W-1:0] r_db_cnt;
    logic            r_filt_bit;

    // filt follows sync only after they have disagreed for DEBOUNCE_CYCLES
    // consecutive cycles; any agreeing cycle restarts the count
    always_ff @(posedge clk) begin
      if (reset) begin
        r_db_cnt   <= '0;
        r_filt_bit <= 1'b0;
      end else if (w_sync[gi] == r_filt_bit) begin
        r_db_cnt   <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_db_cnt   <= '0;
        r_filt_bit <= w_sync[gi];
      end else begin
        r_db_cnt   <= r_db_cnt + DB_ONE;
      end
    end

    assign w_filt[gi] = r_filt_bit;
  end
`else
  assign w_filt = w_sync;
`endif

  // Delayed copy of the filtered input for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev <= '0;
    end else begin
      r_prev <= w_filt;
    end
  end

  // Control/status registers
  logic [WIDTH-1:0]     r_rise_en;
  logic [WIDTH-1:0]     r_fall_en;
  logic [WIDTH-1:0]     r_irq_mask;
  logic                 r_irq_mode;
  logic [WIDTH-1:0]     r_edge_cap;
  logic [CNT_WIDTH-1:0] r_event_cnt;

  logic [WIDTH-1:0]     w_ev;
  logic                 w_ev_any;
  logic [WIDTH-1:0]     w_clr;
  logic [WIDTH-1:0]     w_cap_next;
  logic [CNT_WIDTH-1:0] w_cnt_next;

  assign w_ev     = (w_filt & ~r_prev & r_rise_en) | (~w_filt & r_prev & r_fall_en);
  assign w_ev_any = |w_ev;

  // A fresh edge wins over a same-cycle write-1-to-clear so no event is lost.
  assign w_clr      = (w_wr && (address == ADDR_CAP)) ? w_wdata : '0;
  assign w_cap_next = w_ev | (r_edge_cap & ~w_clr);

  // Next event count: clear (or load 1 on a colliding event), else saturating increment
  always_comb begin
    w_cnt_next = r_event_cnt;
    if (w_wr && (address == ADDR_CNT)) begin
      w_cnt_next = w_ev_any ? CNT_ONE : '0;
    end else if (w_ev_any && !(&r_event_cnt)) begin
      w_cnt_next = r_event_cnt + CNT_ONE;
    end
  end

  // Software-writable configuration registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rise_en  <= '1;
      r_fall_en  <= '0;
      r_irq_mask <= '0;
      r_irq_mode <= 1'b0;
    end else if (w_wr) begin
      case (address)
        ADDR_RISE: r_rise_en  <= w_wdata;
        ADDR_MASK: r_irq_mask <= w_wdata;
        ADDR_FALL: r_fall_en  <= w_wdata;
        ADDR_MODE: r_irq_mode <= writedata[0];
        default:   ;
      endcase
    end
  end

  // Edge capture and event counter update together on the detecting edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_edge_cap  <= '0;
      r_event_cnt <= '0;
    end else begin
      r_edge_cap  <= w_cap_next;
      r_event_cnt <= w_cnt_next;
    end
  end

  // Interrupt: level mode looks at the live filtered input, edge mode at
  // the capture register, so edge-mode irq lags the capture by one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      irq <= 1'b0;
    end else if (r_irq_mode) begin
      irq <= |(r_edge_cap & r_irq_mask);
    end else begin
      irq <= |(w_filt & r_irq_mask);
    end
  end

  // Read mux; unused upper bits and the reserved word read as zero
  logic [31:0] w_rd_mux;

  // Select the register addressed this cycle
  always_comb begin
    w_rd_mux = '0;
    case (address)
      ADDR_DATA: w_rd_mux[WIDTH-1:0] = w_filt;
      ADDR_RISE: w_rd_mux[WIDTH-1:0] = r_rise_en;
      ADDR_MASK: w_rd_mux[WIDTH-1:0] = r_irq_mask;
      ADDR_CAP:  w_rd_mux[WIDTH-1:0] = r_edge_cap;
      ADDR_FALL: w_rd_mux[WIDTH-1:0] = r_fall_en;
      ADDR_MODE: w_rd_mux[0]         = r_irq_mode;
      ADDR_CNT:  w_rd_mux[CNT_WIDTH-1:0] = r_event_cnt;
      default:   w_rd_mux = '0;
    endcase
  end

  // Registered read data, updated every cycle regardless of chipselect
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
    end else begin
      readdata <= w_rd_mux;
    end
  end

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// tb_pio_in_edge_irq: directed scenarios plus randomized bus/input traffic,
// checked every cycle against a behavioural model of the PIO.
`timescale 1ns/1ps
module tb_pio_in_edge_irq;

  localparam int W  = 8;
  localparam int S  = 3;
  localparam int DC = 4;
  localparam int CW = 2;
`ifdef PIO_IN_DEBOUNCE_EN
  localparam int LAT = S + DC;
`else
  localparam int LAT = S;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [2:0]    address = '0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;
  logic [W-1:0]  in_port = '0;
  logic          irq;

  always #5 clk = ~clk;

  pio_in_edge_irq #(
    .WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(DC), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq)
  );

  // ---------------- behavioural model ----------------
  logic [W-1:0] m_q[$];          // in_port samples still travelling through the synchroniser
  logic [W-1:0] m_filt, m_prev, m_rise, m_fall, m_mask, m_cap;
  logic         m_mode;
  int           m_cnt;
  logic [31:0]  m_rd;
  logic         m_irq;
  int           m_run[W];
  logic [W-1:0] t_ev, t_sync, t_clr;
  logic         t_wr;

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_q.delete();
        for (int i = 0; i < S; i++) m_q.push_back('0);
        m_filt = '0; m_prev = '0; m_rise = '1; m_fall = '0;
        m_mask = '0; m_cap = '0; m_mode = 1'b0; m_cnt = 0;
        m_rd = '0; m_irq = 1'b0;
        for (int i = 0; i < W; i++) m_run[i] = 0;
      end else begin
        t_wr = chipselect && !write_n;
        t_ev = (m_filt & ~m_prev & m_rise) | (~m_filt & m_prev & m_fall);
        case (address)
          3'd0: m_rd = 32'(m_filt);
          3'd1: m_rd = 32'(m_rise);
          3'd2: m_rd = 32'(m_mask);
          3'd3: m_rd = 32'(m_cap);
          3'd4: m_rd = 32'(m_fall);
          3'd5: m_rd = 32'(m_mode);
          3'd7: m_rd = 32'(m_cnt);
          default: m_rd = '0;
        endcase
        m_irq = m_mode ? (|(m_cap & m_mask)) : (|(m_filt & m_mask));
        t_clr = (t_wr && address == 3'd3) ? writedata[W-1:0] : '0;
        m_cap = t_ev | (m_cap & ~t_clr);
        if (t_wr && address == 3'd7) m_cnt = (t_ev != 0) ? 1 : 0;
        else if (t_ev != 0 && m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
        if (t_wr) begin
          case (address)
            3'd1: m_rise = writedata[W-1:0];
            3'd2: m_mask = writedata[W-1:0];
            3'd4: m_fall = writedata[W-1:0];
            3'd5: m_mode = writedata[0];
            default: ;
          endcase
        end
        m_prev = m_filt;
        t_sync = m_q[0];
        m_q.push_back(in_port);
        void'(m_q.pop_front());
`ifdef PIO_IN_DEBOUNCE_EN
        for (int i = 0; i < W; i++) begin
          if (t_sync[i] != m_filt[i]) begin
            m_run[i] = m_run[i] + 1;
            if (m_run[i] == DC) begin
              m_filt[i] = t_sync[i];
              m_run[i]  = 0;
            end
          end else begin
            m_run[i] = 0;
          end
        end
`else
        m_filt = m_q[0];
`endif
      end
    end
  end

  // ---------------- compare process ----------------
  int          vectors = 0;
  int          miscompares = 0;
  bit          chk_en = 1'b0;
  int          lit_req = 0;
  int          lit_seen = 0;
  bit          lit_is_irq = 1'b0;
  logic [31:0] lit_exp = '0;
  string       lit_name = "";

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        vectors = vectors + 1;
        if (readdata !== m_rd) begin
          miscompares = miscompares + 1;
          $display("FAIL model_readdata t=%0t addr=%0d got=%h want=%h", $time, address, readdata, m_rd);
        end
        vectors = vectors + 1;
        if (irq !== m_irq) begin
          miscompares = miscompares + 1;
          $display("FAIL model_irq t=%0t got=%b want=%b", $time, irq, m_irq);
        end
      end
      if (lit_req != lit_seen) begin
        lit_seen = lit_req;
        vectors = vectors + 1;
        if (lit_is_irq) begin
          if (irq !== lit_exp[0]) begin
            miscompares = miscompares + 1;
            $display("FAIL %s irq got=%b want=%b", lit_name, irq, lit_exp[0]);
          end else $display("check %s irq=%b", lit_name, irq);
        end else begin
          if (readdata !== lit_exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s readdata got=%h want=%h", lit_name, readdata, lit_exp);
          end else $display("check %s readdata=%h", lit_name, readdata);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_rd(input logic [2:0] a, input logic [31:0] e, input string nm);
    address = a; lit_exp = e; lit_is_irq = 1'b0; lit_name = nm; lit_req = lit_req + 1;
    tick();
  endtask

  task automatic chk_irq(input logic e, input string nm);
    lit_exp = 32'(e); lit_is_irq = 1'b1; lit_name = nm; lit_req = lit_req + 1;
    tick();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset defaults
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    chk_en = 1'b1;
    bus_rd(3'd0, 32'h0,  "rst_data");
    bus_rd(3'd1, 32'hFF, "rst_rise_en");
    bus_rd(3'd2, 32'h0,  "rst_mask");
    bus_rd(3'd3, 32'h0,  "rst_cap");
    bus_rd(3'd4, 32'h0,  "rst_fall_en");
    bus_rd(3'd5, 32'h0,  "rst_mode");
    bus_rd(3'd6, 32'h0,  "rst_reserved");
    bus_rd(3'd7, 32'h0,  "rst_cnt");
    chk_irq(1'b0, "rst_irq");

    // Rising edge, edge mode
    bus_wr(3'd5, 32'h1);
    bus_wr(3'd2, 32'h1);
    in_port = 8'h01;
    tick(LAT + 2);
    bus_rd(3'd3, 32'h1, "rise_cap");
    bus_rd(3'd7, 32'h1, "rise_cnt");
    chk_irq(1'b1, "rise_irq");
    bus_wr(3'd3, 32'h1);
    chk_irq(1'b0, "w1c_irq_drop");
    in_port = 8'h00;
    bus_wr(3'd2, 32'h0);
    tick(LAT + 2);

    // Falling edge only
    bus_wr(3'd1, 32'h0);
    bus_wr(3'd4, 32'h80);
    bus_wr(3'd7, 32'h0);
    bus_wr(3'd3, 32'hFF);
    in_port = 8'h80;
    tick(LAT + 2);
    bus_rd(3'd3, 32'h0, "fall_no_rise");
    in_port = 8'h00;
    tick(LAT + 2);
    bus_rd(3'd3, 32'h80, "fall_cap");
    bus_rd(3'd7, 32'h1, "fall_cnt");

    // Clear/edge collision on bit 3
    bus_wr(3'd4, 32'h0);
    bus_wr(3'd1, 32'h08);
    bus_wr(3'd3, 32'hFF);
    in_port = 8'h08;
    tick(LAT);
    bus_wr(3'd3, 32'h08);
    bus_rd(3'd3, 32'h08, "collide_cap");

    // Level mode
    in_port = 8'h00;
    tick(LAT + 2);
    bus_wr(3'd5, 32'h0);
    bus_wr(3'd2, 32'h04);
    bus_wr(3'd1, 32'h0);
    in_port = 8'h04;
    tick(LAT + 1);
    chk_irq(1'b1, "level_irq");
    in_port = 8'h00;
    tick(LAT + 1);
    chk_irq(1'b0, "level_release");

    // Counter saturation: 5 rising edges on bit 0 with a 2-bit counter
    bus_wr(3'd1, 32'h01);
    bus_wr(3'd7, 32'h0);
    repeat (5) begin
      in_port = 8'h01; tick(LAT + 2);
      in_port = 8'h00; tick(LAT + 2);
    end
    bus_rd(3'd7, 32'h3, "cnt_sat");

`ifdef PIO_IN_DEBOUNCE_EN
    // Debounce: short glitch rejected, long pulse accepted
    bus_wr(3'd1, 32'h02);
    bus_wr(3'd3, 32'hFF);
    in_port = 8'h02; tick(3);
    in_port = 8'h00; tick(LAT + 4);
    bus_rd(3'd3, 32'h0, "db_short");
    in_port = 8'h02; tick(6);
    in_port = 8'h00; tick(LAT + 4);
    bus_rd(3'd3, 32'h02, "db_long");
`endif

    // Randomized traffic, checked every cycle by the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) in_port = W'($urandom);
      address = 3'($urandom);
      writedata = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        chipselect = 1'b1;
        write_n = 1'($urandom_range(0, 1));
      end else begin
        chipselect = 1'($urandom_range(0, 1));
        write_n = 1'b1;
      end
      reset = ($urandom_range(0, 999) == 0);
      tick();
    end
    reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pio_in_edge_irq.md
# pio_in_edge_irq

Parametrised Avalon-MM input PIO with per-bit synchronisation, programmable rising/falling edge capture, a level- or edge-sensitive interrupt and a saturating event counter. It supersedes the fixed 32-bit rising-edge input port and sits on the Nios II data master as a memory-mapped slave; `irq` drives one CPU interrupt line.

## Interface
- `WIDTH`, 32: number of input bits, 1..32.
- `SYNC_STAGES`, 2: synchroniser depth on `in_port`, minimum 2.
- `DEBOUNCE_CYCLES`, 16: stable-cycle count for the debounce filter, 2..65535. Used only when the debounce feature is compiled in.
- `CNT_WIDTH`, 16: event counter width, 1..32.

Ports:
- `clk`  in  1  single clock for the whole block.
- `reset`  in  1  **synchronous, active-high** reset.
- `address`  in  3  word address.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe.
- `writedata`  in  32  write data.
- `readdata`  out  32  registered read data; unused upper bits read 0.
- `in_port`  in  WIDTH  asynchronous external inputs.
- `irq`  out  1  registered interrupt request.

## Operation
- Write strobe is `wr = chipselect & ~write_n`.
- Register map:
  - addr 0: DATA, read-only; filtered input value `filt`.
  - addr 1: RISE_EN, R/W; per-bit rising-edge enable.
  - addr 2: IRQ_MASK, R/W.
  - addr 3: EDGE_CAPTURE; write-1-to-clear.
  - addr 4: FALL_EN, R/W; per-bit falling-edge enable.
  - addr 5: IRQ_MODE, R/W; bit 0 = 0 selects level mode, 1 selects edge mode.
  - addr 6: reserved; reads 0, writes ignored.
  - addr 7: EVENT_CNT; any write clears it.
- Writes use `writedata[WIDTH-1:0]`; IRQ_MODE uses bit 0 only.
- Input path: `in_port` passes through a SYNC_STAGES flop chain to give `sync`. Without debounce, `filt = sync`. `prev` is `filt` registered one cycle later.
- Edge vector: `ev = (filt & ~prev & RISE_EN) | (~filt & prev & FALL_EN)`.
- EDGE_CAPTURE: for each bit, if `ev[i]` then set to 1; else if a W1C write has `writedata[i]` set then clear to 0; else hold. **A new edge beats a same-cycle clear**, so no event is lost.
- IRQ, registered each cycle:
  - level mode: `irq <= |(filt & IRQ_MASK)`.
  - edge mode: `irq <= |(EDGE_CAPTURE & IRQ_MASK)`, using the post-update capture value.
- EVENT_CNT increments by 1 in each cycle where `|ev` is true, and saturates at all-ones. A clear in the same cycle as an event loads 1.
- `readdata <= mux(address)` every cycle, independent of `chipselect`.
- Reset values: `readdata`, `irq`, all registers, sync chain, `prev`, debounce counters and EVENT_CNT are 0. RISE_EN resets to all-ones; FALL_EN resets to 0. At reset the block therefore behaves as a rising-edge port.
- Reset asserted mid-operation clears pending captures and the count on the next `clk` edge. Input transitions that are in flight in the sync chain are discarded.

## Timing
- Read latency is 1 cycle: `readdata` at edge N+1 reflects `address` sampled at edge N.
- Register writes take effect at the sampling edge.
- `in_port` change stable before edge E:
  - appears in `sync`/`filt` after edge E+SYNC_STAGES-1;
  - EDGE_CAPTURE bit set at edge E+SYNC_STAGES;
  - edge-mode `irq` high at edge E+SYNC_STAGES+1;
  - level-mode `irq` high at edge E+SYNC_STAGES.
- EVENT_CNT updates on the same edge as EDGE_CAPTURE.
- A W1C write at edge N drops edge-mode `irq` at edge N+1, provided no other masked capture remains.

## Configuration
- `PIO_IN_DEBOUNCE_EN` defined:
  - each bit has a counter of ceil(log2(DEBOUNCE_CYCLES+1)) bits;
  - while `sync[i] != filt[i]` the counter increments; when it reaches DEBOUNCE_CYCLES, `filt[i]` takes `sync[i]` and the counter clears;
  - any cycle with `sync[i] == filt[i]` clears the counter;
  - this adds DEBOUNCE_CYCLES cycles of latency to every timing figure above.
- `PIO_IN_DEBOUNCE_EN` undefined: `filt = sync`, no counters, and DEBOUNCE_CYCLES is ignored.

## Test plan
- **Reset defaults:** assert `reset` 1 cycle, read each address 0–7 → all 0 except addr 1 = 0xFFFFFFFF; `irq` = 0.
- **Rising edge, edge mode:** write IRQ_MODE=1, IRQ_MASK=0x1; drive `in_port[0]` 0→1 → addr 3 reads 0x1, addr 7 reads 1, `irq` = 1 at the stated edge. Write 0x1 to addr 3 → `irq` = 0 one cycle later.
- **Falling edge only:** write RISE_EN=0, FALL_EN=0x80; toggle bit 7 0→1→0 → capture 0x80 only after the fall; EVENT_CNT = 1.
- **Clear/edge collision:** W1C on bit 3 in the same cycle a bit-3 edge is detected → bit 3 reads 1 afterwards.
- **Level mode and saturation:**
  - IRQ_MODE=0, IRQ_MASK=0x4, hold `in_port`=0x4 → `irq` = 1, and it drops SYNC_STAGES cycles after the input is released;
  - with CNT_WIDTH=2, generate 5 edges → EVENT_CNT = 3.
- **Debounce (macro on, DEBOUNCE_CYCLES=4):** pulse 3 cycles wide → no capture; pulse 6 cycles wide → capture set. Verified with WIDTH=8 and SYNC_STAGES=3.
